// File: rtl/toggle_bank_arbiter.sv
// toggle_bank_arbiter
// Round-robin arbiter sharing one toggle-flop bank among N_REQ requesters.
// Each cycle at most one requester wins; its mask is XORed into the bank.
// The fairness pointer rotates to the slot after the last winner.
module toggle_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] mask,
    output logic [N_REQ-1:0]       gnt,
    output logic [2:0]             gnt_id,
    output logic                   gnt_vld,
    output logic [WIDTH-1:0]       q,
    output logic [15:0]            gnt_cnt
);

    logic [2:0]         ptr;
    logic [2:0]         win;
    logic               win_vld;
    logic [2:0]         ptr_nxt;
    logic [WIDTH-1:0]   win_mask;
    logic [7:0]         req_ext;
    logic [8*WIDTH-1:0] mask_ext;
    logic [7:0]         onehot;

    // Zero-extend to the 8-requester maximum so 3-bit indices are always legal
    always_comb begin
        req_ext               = '0;
        req_ext[N_REQ-1:0]    = req;
        mask_ext              = '0;
        mask_ext[N_REQ*WIDTH-1:0] = mask;
    end

    // Rotating scan starting at ptr picks the first active requester
    always_comb begin
        logic [3:0] idx;
        idx     = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(N_REQ)) begin
                idx = idx - 4'(N_REQ);
            end
            if (!win_vld && req_ext[idx[2:0]]) begin
                win_vld = 1'b1;
                win     = idx[2:0];
            end
        end
    end

    // Winner's mask, one-hot grant and the pointer slot after the winner
    always_comb begin
        win_mask = mask_ext[int'(win)*WIDTH +: WIDTH];
        onehot   = 8'd1 << win;
        ptr_nxt  = (win == 3'(N_REQ-1)) ? 3'd0 : win + 3'd1;
    end

    // Bank, grant outputs, pointer and grant counter; clr outranks any grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            gnt_cnt <= '0;
            ptr     <= '0;
        end else if (clr) begin
            q       <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
        end else if (!win_vld) begin
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
        end else begin
            q       <= q ^ win_mask;
            gnt     <= onehot[N_REQ-1:0];
            gnt_id  <= win;
            gnt_vld <= 1'b1;
            ptr     <= ptr_nxt;
            gnt_cnt <= gnt_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// Directed bench for toggle_bank_arbiter with a reference model feeding a
// scoreboard queue; each expected record is popped after its clock edge.
`timescale 1ns/1ps
module tb_toggle_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [3:0]  req;
    logic [31:0] mask;
    logic [3:0]  gnt;
    logic [2:0]  gnt_id;
    logic        gnt_vld;
    logic [7:0]  q;
    logic [15:0] gnt_cnt;

    typedef struct {
        logic [3:0]  gnt;
        logic [2:0]  id;
        logic        vld;
        logic [7:0]  q;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  m_q;
    int          m_ptr;
    logic [15:0] m_cnt;

    toggle_bank_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .req     (req),
        .mask    (mask),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .q       (q),
        .gnt_cnt (gnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_m(input int i, input logic [7:0] v);
        mask[i*8 +: 8] = v;
    endtask

    task automatic model_reset();
        m_q   = '0;
        m_ptr = 0;
        m_cnt = '0;
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare it
    task automatic step(input string tag, input logic c, input logic [3:0] r);
        exp_t e;
        exp_t got;
        int   w;
        clr = c;
        req = r;
        e.gnt = '0; e.id = '0; e.vld = 1'b0;
        if (!c && r != 4'b0) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            m_q   = m_q ^ mask[w*8 +: 8];
            e.gnt = 4'(1 << w);
            e.id  = 3'(w);
            e.vld = 1'b1;
            m_ptr = (w + 1) % 4;
            m_cnt = m_cnt + 16'd1;
        end else if (c) begin
            m_q = '0;
        end
        e.q   = m_q;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk({tag, "_gnt"},     32'(gnt),     32'(got.gnt));
            chk({tag, "_gnt_id"},  32'(gnt_id),  32'(got.id));
            chk({tag, "_gnt_vld"}, 32'(gnt_vld), 32'(got.vld));
            chk({tag, "_q"},       32'(q),       32'(got.q));
            chk({tag, "_cnt"},     32'(gnt_cnt), 32'(got.cnt));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_q"},       32'(q),       32'd0);
        chk({tag, "_gnt"},     32'(gnt),     32'd0);
        chk({tag, "_gnt_id"},  32'(gnt_id),  32'd0);
        chk({tag, "_gnt_vld"}, 32'(gnt_vld), 32'd0);
        chk({tag, "_cnt"},     32'(gnt_cnt), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        clr   = 1'b0;
        req   = 4'b1111;
        mask  = 32'hFFFF_FFFF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // single requester holding req for three edges
        mask = '0;
        set_m(2, 8'hA5);
        step("single0", 1'b0, 4'b0100);
        step("single1", 1'b0, 4'b0100);
        step("single2", 1'b0, 4'b0100);
        chk("single_q_final", 32'(q), 32'h A5);
        chk("single_cnt_final", 32'(gnt_cnt), 32'd3);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // full round robin from ptr = 0
        for (int i = 0; i < 4; i++) set_m(i, 8'(1 << i));
        for (int i = 0; i < 5; i++) step($sformatf("rr%0d", i), 1'b0, 4'b1111);
        chk("rr_q_final", 32'(q), 32'h0E);

        // pointer fairness with ptr = 1
        step("fair0", 1'b0, 4'b1001);
        chk("fair0_id", 32'(gnt_id), 32'd3);
        step("fair1", 1'b0, 4'b1001);
        chk("fair1_id", 32'(gnt_id), 32'd0);
        step("fair2", 1'b0, 4'b1001);
        chk("fair2_id", 32'(gnt_id), 32'd3);

        // clr collides with a pending grant
        step("clr_pre", 1'b1, 4'b0000);
        set_m(0, 8'h3C);
        step("load3c", 1'b0, 4'b0001);
        set_m(1, 8'h5A);
        step("clr_hit", 1'b1, 4'b0010);
        chk("clr_hit_q", 32'(q), 32'h00);
        step("clr_after", 1'b0, 4'b0010);
        chk("clr_after_q", 32'(q), 32'h5A);

        // idle cycle keeps bank and counter
        step("idle", 1'b0, 4'b0000);

        // zero-mask grants run gnt_cnt up to 0xFFFE
        clr  = 1'b0;
        req  = 4'b0001;
        mask = '0;
        n = 16'hFFFE - int'(m_cnt);
        repeat (n) @(posedge clk);
        #1;
        m_cnt = 16'hFFFE;
        m_ptr = 1;
        chk("burst_cnt", 32'(gnt_cnt), 32'hFFFE);
        chk("burst_q", 32'(q), 32'(m_q));

        set_m(0, 8'h81);
        step("wrap0", 1'b0, 4'b0001);
        chk("wrap0_cnt", 32'(gnt_cnt), 32'hFFFF);
        step("wrap1", 1'b0, 4'b0001);
        chk("wrap1_cnt", 32'(gnt_cnt), 32'h0000);
        set_m(1, 8'h10);
        step("wrap_ptr", 1'b0, 4'b0011);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/toggle_bank_arbiter.md
# toggle_bank_arbiter

Round-robin arbiter that shares one bank of toggle flip-flops among several requesters. Each requester presents a toggle mask; per clock the block grants at most one requester and applies that requester's mask to the bank (bit toggles where the mask bit is 1). It sits between client logic and the toggle-register datapath. It owns the bank state and the fairness pointer, and it reports a grant count for debug.

## Interface

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, toggle bank width in bits.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of the bank (q <= 0).
- req  input  N_REQ  level request per requester; bit i = requester i.
- mask  input  N_REQ*WIDTH  toggle masks; requester i owns bits [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  registered one-hot grant; all-zero when idle.
- gnt_id  output  3  registered index of the granted requester; 0 when idle.
- gnt_vld  output  1  registered, equals |gnt.
- q  output  WIDTH  toggle bank state.
- gnt_cnt  output  16  total grants issued; wraps 0xFFFF -> 0x0000.

## Operation

- Reset (rst_n = 0, asynchronous) forces the following, and they hold while rst_n is low:
  - q = 0, gnt = 0, gnt_id = 0, gnt_vld = 0, gnt_cnt = 0.
  - Priority pointer ptr = 0.
- Each rising edge with rst_n = 1 follows this priority:
  1. clr = 1: q <= 0. Set gnt = 0, gnt_vld = 0 and gnt_id = 0. ptr and gnt_cnt are unchanged. No request is consumed.
  2. Else if req = 0: set gnt = 0, gnt_vld = 0 and gnt_id = 0. q, ptr and gnt_cnt are unchanged.
  3. Else:
     - winner w = first i with req[i] = 1, scanning ptr, ptr+1, … modulo N_REQ.
     - q <= q ^ mask[w*WIDTH +: WIDTH].
     - gnt <= 1<<w, gnt_id <= w, gnt_vld <= 1.
     - ptr <= (w+1) mod N_REQ.
     - gnt_cnt <= gnt_cnt + 1, modulo 2^16.
- Arbitration is stateless apart from ptr. There is no FSM beyond the idle/grant distinction encoded by gnt_vld.
- Requests are level-sensitive:
  - A requester that keeps req high is granted again on its next turn, so each grant produces one toggle.
  - A requester must drop req in the cycle it observes its gnt if it wants exactly one toggle.
- Masks are sampled only for the winner, at the same edge as its grant. Non-granted masks are ignored.
- A mask of all zeros is legal. It consumes a grant and advances ptr, but leaves q unchanged.
- Starvation bound: a requester holding req high is granted within N_REQ cycles, provided clr stays low.

## Timing

- Latency: a request sampled at edge k produces gnt and updated q visible after edge k (same edge). There is no added pipeline stage.
- Throughput: one grant per cycle. Back-to-back grants to different requesters occur on consecutive cycles.
- All outputs are registered. No combinational path exists from any input to any output.
- clr and a grant on the same edge: clr wins, the grant is suppressed and the request stays pending.
- Reset asserted mid-stream: all state clears immediately, without waiting for a clock edge. After deassertion, arbitration restarts at requester 0.
- gnt_cnt wrap: the grant edge that takes 0xFFFF to 0x0000 must not disturb q or ptr.

## Test plan

- Reset: drive req = 4'b1111 and all masks = 8'hFF with rst_n = 0 -> q = 0, gnt = 0, gnt_cnt = 0. Pull rst_n low again mid-run -> outputs return to 0 with no clock edge.
- Single requester:
  - Stimulus: req = 4'b0100, mask2 = 8'hA5, held for 3 edges.
  - Required: gnt = 4'b0100 and gnt_id = 2 on every cycle.
  - Required: q = A5 -> 00 -> A5; gnt_cnt = 3.
- Round robin:
  - Stimulus: req = 4'b1111 with mask_i = 1<<i.
  - Required: gnt sequence 0001, 0010, 0100, 1000, 0001.
  - Required: q = 01, 03, 07, 0F, 0E.
- Pointer fairness:
  - Stimulus: req = 4'b1001, starting after a grant to requester 0 (ptr = 1).
  - Required: next grant goes to 3, then 0, then 3.
- clr collision:
  - Stimulus: q = 8'h3C, req = 4'b0010, clr = 1 for one edge.
  - Required: q = 00 and gnt = 0 for that cycle.
  - Required: on the next edge (clr = 0), gnt = 0010 and q = mask1.
- Counter wrap: preload gnt_cnt to 0xFFFE through 65534 grants (or force), then issue 2 grants -> gnt_cnt = 0xFFFF, then 0x0000, and q still toggles correctly.
